add_align_stage: RTL and testbench

//  Pipelined FP16 adder front-end: unpacks two binary16 operands, orders them by magnitude,

---
 rtl/add_align_if.sv | 30 +++
 rtl/add_align_stage.sv | 103 ++++++++++
 tb/tb_add_align_stage.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/add_align_if.sv
// Operand/result handshake bundle for the FP16 add/align front-end.
// The master drives operands and out_ready; the slave returns results and in_ready.
interface add_align_if #(
  parameter int EXP_W  = 5,
  parameter int FRAC_W = 10
);
  localparam int W = 1 + EXP_W + FRAC_W;

  logic              in_valid;
  logic              in_ready;
  logic [W-1:0]      op_a;
  logic [W-1:0]      op_b;
  logic              out_valid;
  logic              out_ready;
  logic              sign;
  logic              if_carray;
  logic              if_sub;
  logic [EXP_W-1:0]  exponent;
  logic [FRAC_W:0]   mantissa_add;

  modport master (
    output in_valid, op_a, op_b, out_ready,
    input  in_ready, out_valid, sign, if_carray, if_sub, exponent, mantissa_add
  );

  modport slave (
    input  in_valid, op_a, op_b, out_ready,
    output in_ready, out_valid, sign, if_carray, if_sub, exponent, mantissa_add
  );
endinterface

// File: rtl/add_align_stage.sv
// Two-stage FP16 adder front-end: magnitude ordering and unpack, then mantissa
// alignment and add/subtract feeding the downstream normalizer.
module add_align_stage #(
  parameter int EXP_W  = 5,
  parameter int FRAC_W = 10
) (
  input  logic       clk,
  input  logic       rst,
  add_align_if.slave bus
);
  localparam int MANT_W = FRAC_W + 1;
  localparam int MAG_W  = EXP_W + FRAC_W;

  logic vld_p1, vld_p2;
  logic adv1, adv2;

  logic              s_x_p1, sub_p1;
  logic [EXP_W-1:0]  e_x_p1, d_p1;
  logic [MANT_W-1:0] m_x_p1, m_y_p1;

  logic              sign_p2, carry_p2, sub_p2;
  logic [EXP_W-1:0]  exp_p2;
  logic [MANT_W-1:0] mant_p2;

  logic [MAG_W-1:0]  mag_a, mag_b;
  logic [EXP_W-1:0]  e_a, e_b;
  logic [MANT_W-1:0] m_a, m_b;
  logic              swap;

  logic [MANT_W-1:0] m_ys;
  logic [MANT_W:0]   sum;
  logic              cancel;

  // Right shift with everything past the mantissa width flushed to zero; no guard/sticky.
  function automatic logic [MANT_W-1:0] align_shift(input logic [MANT_W-1:0] m,
                                                    input logic [EXP_W-1:0]  d);
    if (int'(d) >= MANT_W) return '0;
    return m >> d;
  endfunction

  assign adv2         = !vld_p2 || bus.out_ready;
  assign adv1         = !vld_p1 || adv2;
  assign bus.in_ready = adv1;

  // Stage 0 -> 1: unpack and order by magnitude (ties keep A as the larger)
  assign mag_a = bus.op_a[MAG_W-1:0];
  assign mag_b = bus.op_b[MAG_W-1:0];
  assign e_a   = bus.op_a[MAG_W-1:FRAC_W];
  assign e_b   = bus.op_b[MAG_W-1:FRAC_W];
  assign m_a   = {|e_a, bus.op_a[FRAC_W-1:0]};
  assign m_b   = {|e_b, bus.op_b[FRAC_W-1:0]};
  assign swap  = mag_b > mag_a;

  // Stage 1 -> 2: align smaller mantissa, add or subtract
  assign m_ys   = align_shift(m_y_p1, d_p1);
  assign sum    = sub_p1 ? {1'b0, m_x_p1 - m_ys} : ({1'b0, m_x_p1} + {1'b0, m_ys});
  assign cancel = sub_p1 && (sum[MANT_W-1:0] == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
    end else begin
      if (adv1) vld_p1 <= bus.in_valid;
      if (adv2) vld_p2 <= vld_p1;
    end
  end

  always_ff @(posedge clk) begin
    if (adv1 && bus.in_valid) begin
      s_x_p1 <= swap ? bus.op_b[MAG_W] : bus.op_a[MAG_W];
      e_x_p1 <= swap ? e_b : e_a;
      m_x_p1 <= swap ? m_b : m_a;
      m_y_p1 <= swap ? m_a : m_b;
      d_p1   <= swap ? (e_b - e_a) : (e_a - e_b);
      sub_p1 <= bus.op_a[MAG_W] ^ bus.op_b[MAG_W];
    end
  end

  // Result registers are cleared on reset so the normalizer never sees stale fields
  always_ff @(posedge clk) begin
    if (rst) begin
      sign_p2  <= 1'b0;
      carry_p2 <= 1'b0;
      sub_p2   <= 1'b0;
      exp_p2   <= '0;
      mant_p2  <= '0;
    end else if (adv2 && vld_p1) begin
      sign_p2  <= cancel ? 1'b0 : s_x_p1;
      carry_p2 <= sum[MANT_W];
      sub_p2   <= sub_p1;
      exp_p2   <= cancel ? '0 : e_x_p1;
      mant_p2  <= sum[MANT_W-1:0];
    end
  end

  assign bus.out_valid    = vld_p2;
  assign bus.sign         = sign_p2;
  assign bus.if_carray    = carry_p2;
  assign bus.if_sub       = sub_p2;
  assign bus.exponent     = exp_p2;
  assign bus.mantissa_add = mant_p2;
endmodule

// File: tb/tb_add_align_stage.sv
// Randomized and directed bench for add_align_stage with a value-level reference model
// and an in-order scoreboard.
module tb_add_align_stage;
  logic clk = 1'b0;
  logic rst;

  add_align_if #(.EXP_W(5), .FRAC_W(10)) bus ();

  add_align_stage #(.EXP_W(5), .FRAC_W(10)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int n_out = 0;
  logic acc = 1'b0;
  logic [31:0] sb[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  // Packed view {sign, if_carray, if_sub, exponent, mantissa_add}
  function automatic logic [31:0] fields();
    return 32'({bus.sign, bus.if_carray, bus.if_sub, bus.exponent, bus.mantissa_add});
  endfunction

  function automatic logic [31:0] pack(input int s, input int c, input int sub,
                                       input int e, input int m);
    return (32'(s) << 18) | (32'(c) << 17) | (32'(sub) << 16) | (32'(e) << 11) | 32'(m);
  endfunction

  // Reference: work on integer magnitudes and mantissas straight from the FP16 fields
  function automatic logic [31:0] model(input logic [15:0] a, input logic [15:0] b);
    int ea, eb, ma, mb, ex, mx, my, d, mys, r, sx, sub;
    ea  = int'(a[14:10]);
    eb  = int'(b[14:10]);
    ma  = (ea != 0 ? 1024 : 0) + int'(a[9:0]);
    mb  = (eb != 0 ? 1024 : 0) + int'(b[9:0]);
    sub = int'(a[15] ^ b[15]);
    if (int'(b[14:0]) > int'(a[14:0])) begin
      sx = int'(b[15]); ex = eb; mx = mb; my = ma; d = eb - ea;
    end else begin
      sx = int'(a[15]); ex = ea; mx = ma; my = mb; d = ea - eb;
    end
    mys = (d >= 11) ? 0 : my / (1 << d);
    r   = (sub != 0) ? mx - mys : mx + mys;
    if (sub != 0 && r == 0) return pack(0, 0, 1, 0, 0);
    return pack(sx, (r >= 2048) ? 1 : 0, sub, ex, r % 2048);
  endfunction

  // One clock: observe handshakes mid-cycle, then step past the rising edge
  task automatic tick();
    logic [31:0] e;
    @(negedge clk);
    acc = bus.in_valid && bus.in_ready;
    if (acc) sb.push_back(model(bus.op_a, bus.op_b));
    if (bus.out_valid && bus.out_ready) begin
      if (sb.size() == 0) chk("unexpected_out", 32'(1), 32'(0));
      else begin
        e = sb.pop_front();
        chk("result", fields(), e);
        n_out++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic directed(input string tag, input logic [15:0] a, input logic [15:0] b,
                          input logic [31:0] e);
    int lat;
    bus.op_a = a; bus.op_b = b; bus.in_valid = 1'b1; bus.out_ready = 1'b1;
    chk({tag, "_in_ready"}, 32'(bus.in_ready), 32'(1));
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    lat = 1;
    while (!bus.out_valid && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, "_latency"}, 32'(lat), 32'(2));
    chk(tag, fields(), e);
    @(posedge clk); #1;
  endtask

  function automatic logic [15:0] rand_op();
    logic [15:0] r;
    r = 16'($urandom);
    if ($urandom_range(0, 9) == 0) r[14:10] = 5'd0;
    return r;
  endfunction

  task automatic rand_stream(input int n, input int stall_pct);
    int sent, guard;
    sent = 0; guard = 0;
    acc = 1'b0;
    bus.in_valid = 1'b0;
    while ((sent < n || sb.size() != 0) && guard < 5000) begin
      if (!bus.in_valid || acc) begin
        if (sent < n && $urandom_range(0, 99) >= 20) begin
          bus.in_valid = 1'b1;
          bus.op_a = rand_op();
          case ($urandom_range(0, 9))
            0: bus.op_b = bus.op_a ^ 16'h8000;
            1: bus.op_b = bus.op_a;
            default: bus.op_b = rand_op();
          endcase
        end else bus.in_valid = 1'b0;
      end
      bus.out_ready = ($urandom_range(0, 99) >= stall_pct);
      tick();
      if (acc) sent++;
      guard++;
    end
    bus.in_valid = 1'b0;
    chk("stream_drain", 32'(guard < 5000), 32'(1));
  endtask

  task automatic stall_test();
    logic [31:0] held;
    logic [15:0] ops [6];
    int k, base;
    for (int i = 0; i < 6; i++) ops[i] = rand_op();
    base = n_out;
    k = 0;
    held = '0;
    bus.in_valid = 1'b1; bus.op_a = ops[0]; bus.op_b = ops[5];
    for (int c = 0; c < 40 && (k < 6 || sb.size() != 0); c++) begin
      bus.out_ready = (c >= 5);
      if (c >= 2 && c < 5) begin
        chk("stall_in_ready", 32'(bus.in_ready), 32'(0));
        chk("stall_out_valid", 32'(bus.out_valid), 32'(1));
        if (c == 2) held = fields();
        else chk("stall_hold", fields(), held);
      end
      tick();
      if (acc) begin
        k++;
        if (k < 6) begin bus.op_a = ops[k]; bus.op_b = ops[5 - k]; end
        else bus.in_valid = 1'b0;
      end
    end
    bus.in_valid = 1'b0;
    chk("stall_count", 32'(n_out - base), 32'(6));
  endtask

  task automatic reset_test();
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.op_a = 16'h3C00; bus.op_b = 16'h4000;
    tick();
    bus.op_a = 16'h4400; bus.op_b = 16'h3800;
    tick();
    bus.in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    sb.delete();
    chk("rst_out_valid", 32'(bus.out_valid), 32'(0));
    chk("rst_data", fields(), 32'(0));
    rst = 1'b0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("rst_no_stale", 32'(bus.out_valid), 32'(0));
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    bus.op_a = '0; bus.op_b = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_out_valid", 32'(bus.out_valid), 32'(0));
    chk("reset_data", fields(), 32'(0));
    rst = 1'b0;
    @(posedge clk); #1;
    chk("reset_in_ready", 32'(bus.in_ready), 32'(1));

    directed("one_plus_one",  16'h3C00, 16'h3C00, pack(0, 1, 0, 15, 16'h000));
    directed("one_minus_half", 16'h3C00, 16'hB800, pack(0, 0, 1, 15, 16'h200));
    directed("one_minus_two",  16'h3C00, 16'hC000, pack(1, 0, 1, 16, 16'h200));
    directed("exact_cancel",   16'h3C00, 16'hBC00, pack(0, 0, 1, 0, 0));
    directed("far_apart",      16'h7800, 16'h3C00, pack(0, 0, 0, 30, 16'h400));

    stall_test();
    rand_stream(300, 0);
    rand_stream(300, 40);
    reset_test();
    rand_stream(100, 25);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
